amp_adc_responder: RTL
======================

AMP_ADC_RESPONDER -- requirements
Module: amp_adc_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for spi_sck, spi_mosi, amp_cs, ad_conv, amp_shdn.
REQ-002 SHALL have parameter DATA_W, default 14, width of each ADC sample.
REQ-003 SHALL have port clk  input  1  single system clock; every flop is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port spi_sck  input  1  SPI clock from master; asynchronous to clk.
REQ-006 SHALL have port spi_mosi  input  1  serial gain data, MSB first.
REQ-007 SHALL have port amp_cs  input  1  amplifier chip select, active-low.
REQ-008 SHALL have port amp_shdn  input  1  amplifier shutdown, active-high.
REQ-009 SHALL have port ad_conv  input  1  conversion start; the rising edge starts a frame.
REQ-010 SHALL have port sample_a, sample_b  input  DATA_W  channel values captured at conversion start.
REQ-011 SHALL have port spi_miso  output  1  ADC serial data.
REQ-012 SHALL have port miso_oe  output  1  1 = spi_miso driven, 0 = Hi-Z slot.
REQ-013 SHALL have port amp_dout  output  1  echo of the previous gain word.
REQ-014 SHALL have port gain_a, gain_b  output  4  live gain codes, gain_a = word[3:0], gain_b = word[7:4].
REQ-015 SHALL have ports gain_valid, gain_err, frame_done, conv_overrun  output  1 each  one-clk pulses.
REQ-016 SHALL have port frame_busy  output  1  high while an ADC frame is in progress.

Function
REQ-017 SHALL synchronize all SPI inputs with SYNC_STAGES flops, then detect edges on the synchronized copies; all actions occur on detected edges.
REQ-018 SHALL operate correctly for spi_sck high and low times of at least 4 clk cycles each.
REQ-019 SHALL update each output on the third clk edge or earlier after the pin-level spi_sck edge that causes the update.
REQ-020 Gain path: amp_cs falling edge SHALL clear the bit counter and load the dout shifter with the current {gain_b,gain_a}; amp_dout SHALL then drive bit 7.
REQ-021 On each spi_sck rising edge while amp_cs is low, the block SHALL shift spi_mosi into an 8-bit shift register from the LSB end and increment the bit counter, which saturates at 15.
REQ-022 On each spi_sck falling edge while amp_cs is low, the dout shifter SHALL shift left, and amp_dout SHALL follow its MSB.
REQ-023 amp_cs rising edge with count == 8: gain_a/gain_b SHALL update from the shift register and gain_valid SHALL pulse.
REQ-024 amp_cs rising edge with count != 8 (including 0): gains SHALL stay unchanged and gain_err SHALL pulse.
REQ-025 While amp_cs is high, amp_dout SHALL be 0.
REQ-026 While amp_shdn is high, gain_a and gain_b SHALL be forced to 0 and gain updates SHALL be discarded without a pulse.
REQ-027 ADC FSM states SHALL be IDLE, LEAD, DATA_A, GAP, DATA_B, TAIL.
REQ-028 In IDLE, an ad_conv rising edge SHALL capture sample_a/sample_b, set frame_busy, clear the falling-edge index k, and go to LEAD.
REQ-029 The index k SHALL increment on each spi_sck falling edge while frame_busy is set.
REQ-030 For k = 1,2 (LEAD), 17,18 (GAP) and 33,34 (TAIL), the block SHALL drive miso_oe = 0 and spi_miso = 0.
REQ-031 For k = 3..16 (DATA_A), the block SHALL drive miso_oe = 1 and spi_miso = A[16-k], so A[13] goes first.
REQ-032 For k = 19..32 (DATA_B), the block SHALL drive miso_oe = 1 and spi_miso = B[32-k].
REQ-033 At k = 34, frame_done SHALL pulse, frame_busy SHALL clear, and the FSM SHALL return to IDLE.
REQ-034 Before the first falling edge of a frame, miso_oe SHALL be 0.
REQ-035 An ad_conv rising edge while frame_busy is set SHALL be ignored for data, and conv_overrun SHALL pulse.
REQ-036 An ad_conv rising edge on the same clk as k = 34 SHALL count as an overrun and SHALL NOT start a new frame.
REQ-037 The gain path and the ADC path SHALL run independently; concurrent activity on both SHALL be legal.

Reset
REQ-038 rst low SHALL immediately force: FSM to IDLE, k = 0, gain counter = 0, gain_a = gain_b = 0, spi_miso = 0, miso_oe = 0, amp_dout = 0, frame_busy = 0, all pulses = 0, synchronizers = idle levels (sck 0, cs 1, conv 0).
REQ-039 A reset mid-frame or mid-gain-write SHALL abort it with no done, valid or err pulse; the first ad_conv rising edge after rst releases SHALL start a clean frame.

Verification
REQ-040 Gain write 8'b0001_0001, cs low, 8 sck at 8-clk period -> gain_valid once, gain_a = 1, gain_b = 1; the next write echoes 0x11 on amp_dout, MSB first.
REQ-041 6-bit write -> gain_err once, gains unchanged; the same write with amp_shdn = 1 -> gains read 0 and no pulse.
REQ-042 sample_a = 14'h2AAA, sample_b = 14'h1555, ad_conv pulse, 34 sck -> master rising-edge capture yields A = 2AAA, B = 1555; miso_oe low in slots 1,2,17,18,33,34; frame_done at k = 34.
REQ-043 Second ad_conv at k = 10 -> conv_overrun pulse, frame data unaffected, frame_done still at k = 34.
REQ-044 rst asserted at k = 20 -> all outputs at reset values within 0 clk; next frame with A = 14'h0001 is read correctly.
REQ-045 Gain write overlapping an ADC frame -> both complete correctly with no interference.

Source files
------------

// File: rtl/amp_adc_responder.sv
// -----------------------------------------------------------------------------
// amp_adc_responder
//
// Slave-side model of a programmable pre-amplifier plus a two-channel ADC that
// share one SPI clock. Every pin from the master is brought into the clk
// domain through a SYNC_STAGES-deep synchronizer. All actions happen on
// edges detected on the synchronized copies.
//
// Gain path (amp_cs framed):
//   An 8-bit gain word is shifted in MSB first on spi_sck rising edges. A
//   write that ends with exactly 8 bits updates gain_a/gain_b. The previous
//   gain word is echoed on amp_dout, MSB first, changing on spi_sck falling
//   edges.
//
// ADC path (ad_conv framed):
//   A rising edge of ad_conv captures sample_a/sample_b. The falling edges of
//   spi_sck are then numbered k = 1..34:
//     k = 1,2   Hi-Z
//     k = 3..16 channel A, MSB first
//     k = 17,18 Hi-Z
//     k = 19..32 channel B, MSB first
//     k = 33,34 Hi-Z
//
// Ports:
//   clk, rst                      system clock, async active-low reset
//   spi_sck, spi_mosi             SPI clock and gain data from the master
//   amp_cs, amp_shdn              amplifier select (low), shutdown (high)
//   ad_conv                       conversion start (rising edge)
//   sample_a, sample_b            channel values captured at conversion start
//   spi_miso, miso_oe             ADC serial data and its drive enable
//   amp_dout                      echo of the previous gain word
//   gain_a, gain_b                live gain codes
//   gain_valid, gain_err          one-clk gain write result pulses
//   frame_done, conv_overrun      one-clk ADC frame pulses
//   frame_busy                    ADC frame in progress
// -----------------------------------------------------------------------------
module amp_adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              amp_cs,
    input  logic              amp_shdn,
    input  logic              ad_conv,
    input  logic [DATA_W-1:0] sample_a,
    input  logic [DATA_W-1:0] sample_b,
    output logic              spi_miso,
    output logic              miso_oe,
    output logic              amp_dout,
    output logic [3:0]        gain_a,
    output logic [3:0]        gain_b,
    output logic              gain_valid,
    output logic              gain_err,
    output logic              frame_done,
    output logic              conv_overrun,
    output logic              frame_busy
);

    // Slot boundaries, expressed as the last k of each region.
    localparam int K_LEAD_END  = 2;
    localparam int K_A_END     = K_LEAD_END + DATA_W;
    localparam int K_GAP_END   = K_A_END + 2;
    localparam int K_B_END     = K_GAP_END + DATA_W;
    localparam int K_FRAME_END = K_B_END + 2;
    localparam int KW          = $clog2(K_FRAME_END + 1);

    // Synchronizer bit order {shdn, conv, cs, mosi, sck}; idle levels on the right.
    localparam logic [4:0] SYNC_IDLE = 5'b00100;
    // Edge-detect history bit order {conv, cs, sck}.
    localparam logic [2:0] PREV_IDLE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_DATA_A,
        S_GAP,
        S_DATA_B,
        S_TAIL
    } adc_state_t;

    // ------------------------------------------------------------------ sync
    logic [4:0] sync_q [SYNC_STAGES];
    logic [2:0] prev_q;
    logic [4:0] pins;
    logic [4:0] now_s;

    assign pins  = {amp_shdn, ad_conv, amp_cs, spi_mosi, spi_sck};
    assign now_s = sync_q[SYNC_STAGES-1];

    // NOTE: the synchronizer array is reset on purpose. It must come out of
    // reset at the idle pin levels; otherwise a false chip-select or
    // conversion edge could be detected right after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            prev_q <= PREV_IDLE;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= {now_s[3], now_s[2], now_s[0]};
        end
    end

    logic sck_s, mosi_s, cs_s, conv_s, shdn_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall, conv_rise;

    assign sck_s     = now_s[0];
    assign mosi_s    = now_s[1];
    assign cs_s      = now_s[2];
    assign conv_s    = now_s[3];
    assign shdn_s    = now_s[4];
    assign sck_rise  =  sck_s  & ~prev_q[0];
    assign sck_fall  = ~sck_s  &  prev_q[0];
    assign cs_rise   =  cs_s   & ~prev_q[1];
    assign cs_fall   = ~cs_s   &  prev_q[1];
    assign conv_rise =  conv_s & ~prev_q[2];

    // ------------------------------------------------------------- gain path
    logic [3:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] dout_sh;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            shift_in   <= '0;
            dout_sh    <= '0;
            amp_dout   <= 1'b0;
            gain_a     <= '0;
            gain_b     <= '0;
            gain_valid <= 1'b0;
            gain_err   <= 1'b0;
        end else begin
            gain_valid <= 1'b0;
            gain_err   <= 1'b0;

            if (cs_fall) begin
                bit_cnt  <= '0;
                dout_sh  <= {gain_b, gain_a};
                amp_dout <= gain_b[3];
            end else if (!cs_s) begin
                if (sck_rise) begin
                    shift_in <= {shift_in[6:0], mosi_s};
                    if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
                end
                if (sck_fall) begin
                    dout_sh  <= {dout_sh[6:0], 1'b0};
                    amp_dout <= dout_sh[6];
                end
            end else begin
                amp_dout <= 1'b0;
            end

            // A write that ends during shutdown is dropped silently.
            if (cs_rise && !shdn_s) begin
                if (bit_cnt == 4'd8) begin
                    gain_a     <= shift_in[3:0];
                    gain_b     <= shift_in[7:4];
                    gain_valid <= 1'b1;
                end else begin
                    gain_err <= 1'b1;
                end
            end

            // Shutdown clears the stored gains, so they stay 0 after release
            // until a new write arrives.
            if (shdn_s) begin
                gain_a <= '0;
                gain_b <= '0;
            end
        end
    end

    // -------------------------------------------------------------- ADC path
    adc_state_t        state, state_n;
    logic [KW-1:0]     k, k_n;
    logic [DATA_W-1:0] sh_a, sh_a_n, sh_b, sh_b_n;
    logic              miso_n, oe_n, done_n, ovr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            k            <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            spi_miso     <= 1'b0;
            miso_oe      <= 1'b0;
            frame_done   <= 1'b0;
            conv_overrun <= 1'b0;
        end else begin
            state        <= state_n;
            k            <= k_n;
            sh_a         <= sh_a_n;
            sh_b         <= sh_b_n;
            spi_miso     <= miso_n;
            miso_oe      <= oe_n;
            frame_done   <= done_n;
            conv_overrun <= ovr_n;
        end
    end

    // The captured samples are held in shifters. Each data slot sends the MSB
    // and then shifts, so no variable bit index is needed.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this
        // block leaves a value unassigned and no latch is inferred.
        state_n = state;
        k_n     = k;
        sh_a_n  = sh_a;
        sh_b_n  = sh_b;
        miso_n  = spi_miso;
        oe_n    = miso_oe;
        done_n  = 1'b0;
        ovr_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (conv_rise) begin
                    state_n = S_LEAD;
                    k_n     = '0;
                    sh_a_n  = sample_a;
                    sh_b_n  = sample_b;
                    miso_n  = 1'b0;
                    oe_n    = 1'b0;
                end
            end
            default: begin
                // A conversion edge during a frame, including one on the
                // closing k = 34 edge, is reported and otherwise ignored.
                if (conv_rise) ovr_n = 1'b1;
                if (sck_fall) begin
                    k_n    = k + 1'b1;
                    miso_n = 1'b0;
                    oe_n   = 1'b0;
                    if (k_n <= KW'(K_LEAD_END)) begin
                        state_n = S_LEAD;
                    end else if (k_n <= KW'(K_A_END)) begin
                        state_n = S_DATA_A;
                        oe_n    = 1'b1;
                        miso_n  = sh_a[DATA_W-1];
                        sh_a_n  = {sh_a[DATA_W-2:0], 1'b0};
                    end else if (k_n <= KW'(K_GAP_END)) begin
                        state_n = S_GAP;
                    end else if (k_n <= KW'(K_B_END)) begin
                        state_n = S_DATA_B;
                        oe_n    = 1'b1;
                        miso_n  = sh_b[DATA_W-1];
                        sh_b_n  = {sh_b[DATA_W-2:0], 1'b0};
                    end else if (k_n < KW'(K_FRAME_END)) begin
                        state_n = S_TAIL;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign frame_busy = (state != S_IDLE);

endmodule
